// File: rtl/cw_winnow_if.sv
// Packet-in / result-out handshake bundle for the chaffing-and-winnowing receiver.
interface cw_winnow_if #(
  parameter int CWBITS  = 32,
  parameter int CTRSIZE = 16,
  parameter int TAGSIZE = 16
);
  logic                       in_valid;
  logic                       in_ready;
  logic [CTRSIZE+TAGSIZE:0]   in_pkt;
  logic                       out_valid;
  logic                       out_ready;
  logic [CWBITS-1:0]          msg;
  logic                       err;

  modport master (
    output in_valid, in_pkt, out_ready,
    input  in_ready, out_valid, msg, err
  );

  modport slave (
    input  in_valid, in_pkt, out_ready,
    output in_ready, out_valid, msg, err
  );
endinterface

// File: rtl/cw_winnow.sv
// Winnower: keeps MAC-authentic packets, drops chaff, reassembles a CWBITS-wide message.
// Optional CW_STATS_EN adds a saturating per-frame chaff counter output.
//   state     | meaning
//   S_IDLE    | waiting for start, no packet intake
//   S_COLLECT | accepting 2*CWBITS packets, one per cycle
//   S_DONE    | result presented until out_ready
module cw_winnow #(
  parameter int CWBITS  = 32,
  parameter int CTRSIZE = 16,
  parameter int TAGSIZE = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               start_i,
  input  logic [TAGSIZE-1:0] key_i,
  cw_winnow_if.slave         bus
`ifdef CW_STATS_EN
  ,output logic [15:0]       chaff_cnt_o
`endif
);

  localparam int IDXW = (CWBITS > 1) ? $clog2(CWBITS) : 1;
  localparam int CNTW = $clog2(2*CWBITS+1);
  localparam logic [CNTW-1:0]  LAST   = CNTW'(2*CWBITS-1);
  localparam logic [CTRSIZE:0] CW_LIM = (CTRSIZE+1)'(CWBITS);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t              state_q;
  logic [TAGSIZE-1:0]  key_q;
  logic [CWBITS-1:0]   msg_q, msg_d;
  logic [CWBITS-1:0]   seen_q, seen_d;
  logic                conflict_q, conflict_d;
  logic [CNTW-1:0]     pkt_cnt_q, pkt_cnt_d;
  logic                err_q;

  logic [CTRSIZE-1:0]  pkt_ctr;
  logic [TAGSIZE-1:0]  pkt_tag;
  logic                pkt_bit;
  logic [TAGSIZE-1:0]  ctr_t;
  logic [TAGSIZE-1:0]  exp_tag;
  logic [IDXW-1:0]     idx;
  logic                accept;
  logic                is_auth;

  assign pkt_ctr = bus.in_pkt[CTRSIZE+TAGSIZE:TAGSIZE+1];
  assign pkt_tag = bus.in_pkt[TAGSIZE:1];
  assign pkt_bit = bus.in_pkt[0];
  assign ctr_t   = TAGSIZE'(pkt_ctr);
  assign exp_tag = key_q ^ ctr_t ^ {TAGSIZE{pkt_bit}};
  assign idx     = pkt_ctr[IDXW-1:0];
  assign accept  = bus.in_valid && (state_q == S_COLLECT);
  // Range check must come before idx is trusted; idx is only the low bits of ctr.
  assign is_auth = (pkt_tag == exp_tag) && ({1'b0, pkt_ctr} < CW_LIM);

  always_comb begin
    msg_d      = msg_q;
    seen_d     = seen_q;
    conflict_d = conflict_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (accept) begin
      pkt_cnt_d = pkt_cnt_q + 1'b1;
      if (is_auth) begin
        if (!seen_q[idx]) begin
          seen_d[idx] = 1'b1;
          msg_d[idx]  = pkt_bit;
        end else if (msg_q[idx] != pkt_bit) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      msg_q      <= '0;
      seen_q     <= '0;
      conflict_q <= 1'b0;
      pkt_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            key_q      <= key_i;
            msg_q      <= '0;
            seen_q     <= '0;
            conflict_q <= 1'b0;
            pkt_cnt_q  <= '0;
            err_q      <= 1'b0;
            state_q    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          msg_q      <= msg_d;
          seen_q     <= seen_d;
          conflict_q <= conflict_d;
          pkt_cnt_q  <= pkt_cnt_d;
          if (accept && (pkt_cnt_q == LAST)) begin
            err_q   <= conflict_d | ~&seen_d;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_COLLECT);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.msg       = msg_q;
  assign bus.err       = err_q;

`ifdef CW_STATS_EN
  logic [15:0] chaff_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      chaff_q <= '0;
    end else if ((state_q == S_IDLE) && start_i) begin
      chaff_q <= '0;
    end else if (accept && !is_auth && (chaff_q != 16'hFFFF)) begin
      chaff_q <= chaff_q + 16'd1;
    end
  end

  assign chaff_cnt_o = chaff_q;
`endif

endmodule

// File: tb/tb_cw_winnow.sv
// Directed bench for cw_winnow with CWBITS=4 and key 16'hA5A5.
module tb_cw_winnow;
  localparam int CWBITS  = 4;
  localparam int CTRSIZE = 16;
  localparam int TAGSIZE = 16;
  localparam logic [15:0] KEY = 16'hA5A5;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] key_i = '0;
`ifdef CW_STATS_EN
  logic [15:0] chaff_cnt_o;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [32:0] pkts [8];

  cw_winnow_if #(.CWBITS(CWBITS), .CTRSIZE(CTRSIZE), .TAGSIZE(TAGSIZE)) bus ();

  cw_winnow #(.CWBITS(CWBITS), .CTRSIZE(CTRSIZE), .TAGSIZE(TAGSIZE)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .start_i     (start_i),
    .key_i       (key_i),
    .bus         (bus.slave)
`ifdef CW_STATS_EN
    ,.chaff_cnt_o(chaff_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] atag(input int c, input logic b);
    return KEY ^ 16'(c) ^ {16{b}};
  endfunction

  function automatic logic [32:0] auth_pkt(input int c, input logic b);
    return {16'(c), atag(c, b), b};
  endfunction

  function automatic logic [32:0] chaff_pkt(input int c, input logic b);
    return {16'(c), 16'h0000, b};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [32:0] p);
    bus.in_valid = 1'b1;
    bus.in_pkt   = p;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic start_frame(input string nm);
    start_i = 1'b1;
    key_i   = KEY;
    tick();
    start_i = 1'b0;
    chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic load_clean(input logic [3:0] m, input bit rev);
    for (int i = 0; i < 4; i++) begin
      pkts[2*i]   = rev ? chaff_pkt(i, ~m[i]) : auth_pkt(i, m[i]);
      pkts[2*i+1] = rev ? auth_pkt(i, m[i])   : chaff_pkt(i, ~m[i]);
    end
  endtask

  task automatic run_frame(input int max_gap, input string nm);
    for (int i = 0; i < 8; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
      if (i == 7) chk({nm, "_ov_before_last"}, 32'(bus.out_valid), 32'd0);
      send(pkts[i]);
    end
    chk({nm, "_ov_after_last"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic finish_frame(input string nm, input logic [3:0] m, input logic e, input int chaff);
    chk({nm, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
    chk({nm, "_msg"}, 32'(bus.msg), 32'(m));
    chk({nm, "_err"}, 32'(bus.err), 32'(e));
`ifdef CW_STATS_EN
    chk({nm, "_chaff"}, 32'(chaff_cnt_o), 32'(chaff));
`else
    if (chaff < 0) $display("negative chaff count %0d", chaff);
`endif
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({nm, "_ov_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pkt    = '0;
    bus.out_ready = 1'b0;
    #3;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_msg", 32'(bus.msg), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    tick();
    rstn_i = 1'b1;
    tick();
    tick();
    chk("idle_no_start", 32'(bus.in_ready), 32'd0);

    // clean frame, authentic first
    start_frame("clean");
    load_clean(4'b1010, 1'b0);
    run_frame(0, "clean");
    finish_frame("clean", 4'b1010, 1'b0, 4);

    // reversed order with random gaps
    start_frame("rev");
    load_clean(4'b1010, 1'b1);
    run_frame(3, "rev");
    finish_frame("rev", 4'b1010, 1'b0, 4);

    // index 3 has only chaff
    start_frame("miss");
    load_clean(4'b1010, 1'b0);
    pkts[6] = chaff_pkt(3, 1'b1);
    run_frame(0, "miss");
    finish_frame("miss", 4'b0010, 1'b1, 5);

    // conflicting authentic copies for ctr=2
    start_frame("conf");
    load_clean(4'b1010, 1'b0);
    pkts[4] = {16'd2, 16'h5A58, 1'b1};
    pkts[5] = {16'd2, 16'hA5A7, 1'b0};
    run_frame(0, "conf");
    finish_frame("conf", 4'b1110, 1'b1, 3);

    // out-of-range ctr=5 with a formula-matching tag, then hold out_ready low
    start_frame("oor");
    load_clean(4'b1010, 1'b0);
    pkts[1] = {16'd5, 16'h5A5F, 1'b1};
    run_frame(0, "oor");
    for (int k = 0; k < 10; k++) begin
      start_i = (k == 4);
      key_i   = 16'h1234;
      tick();
      start_i = 1'b0;
      chk("oor_hold_ov", 32'(bus.out_valid), 32'd1);
      chk("oor_hold_msg", 32'(bus.msg), 32'b1010);
    end
    finish_frame("oor", 4'b1010, 1'b0, 4);

    // start coincident with DONE->IDLE is dropped
    start_frame("coin");
    load_clean(4'b0101, 1'b0);
    run_frame(0, "coin");
    bus.out_ready = 1'b1;
    start_i       = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    start_i       = 1'b0;
    chk("coin_ov_drop", 32'(bus.out_valid), 32'd0);
    chk("coin_start_ignored", 32'(bus.in_ready), 32'd0);
    chk("coin_msg_held", 32'(bus.msg), 32'b0101);

    // reset after three accepts
    start_frame("midrst");
    load_clean(4'b1010, 1'b0);
    for (int i = 0; i < 3; i++) send(pkts[i]);
    rstn_i = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_msg", 32'(bus.msg), 32'd0);
    chk("midrst_err", 32'(bus.err), 32'd0);
`ifdef CW_STATS_EN
    chk("midrst_chaff", 32'(chaff_cnt_o), 32'd0);
`endif
    tick();
    rstn_i = 1'b1;
    tick();
    chk("midrst_idle", 32'(bus.in_ready), 32'd0);
    start_frame("after");
    load_clean(4'b0110, 1'b0);
    run_frame(2, "after");
    finish_frame("after", 4'b0110, 1'b0, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/cw_winnow.md
# cw_winnow

Receive-side winnower for the chaffing-and-winnowing link. It consumes the stream of packets that the chaffer emits (2*cwbits packets per frame, one authentic and one chaff per message bit) and checks each packet's tag against a keyed MAC. It keeps the authentic bits, discards chaff and reassembles the cwbits-wide message. The result is presented with a valid/ready handshake.

## Interface
- cwbits, 32: message bits per frame; a frame is 2*cwbits packets.
- ctrsize, 16: counter field width; the counter carries the bit index.
- tagsize, 16: MAC tag width.
- clk  input  1  single clock; all logic is on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- key  input  tagsize  MAC key; sampled on an accepted start.
- in_valid  input  1  a packet is present on in_pkt.
- in_ready  output  1  the block accepts a packet this cycle.
- in_pkt  input  ctrsize+tagsize+1  packet layout:
  - [ctrsize+tagsize:tagsize+1] = ctr
  - [tagsize:1] = tag
  - [0] = bit
- out_valid  output  1  msg and err are valid.
- out_ready  input  1  the consumer takes the result.
- msg  output  cwbits  reassembled message; msg[i] is the bit for index i.
- err  output  1  the frame is incomplete or conflicting.

## Operation
- Expected tag: exp = key_r ^ ctr_t ^ {tagsize{bit}}.
  - key_r is the latched key.
  - ctr_t is ctr zero-extended or truncated to tagsize bits.
- A packet is authentic when tag == exp **and** ctr < cwbits. Any other packet is chaff.
- FSM states: IDLE, COLLECT, DONE.
  - IDLE: in_ready=0. On start=1: latch key, clear msg, seen[], conflict and pkt_cnt, then go to COLLECT. Nothing changes without start.
  - COLLECT: in_ready=1. An accept is in_valid&in_ready. On each accept:
    - pkt_cnt increments.
    - Authentic packet with seen[ctr]=0: set msg[ctr]=bit and seen[ctr]=1.
    - Authentic packet with seen[ctr]=1 and a different bit: set conflict=1; msg[ctr] keeps its first value.
    - Authentic duplicate with the same bit: no effect.
    - Chaff: no effect on msg, seen or conflict.
    - When the accept makes pkt_cnt reach 2*cwbits, go to DONE.
  - DONE: in_ready=0, out_valid=1, err = conflict | ~&seen. On out_ready=1, go to IDLE; msg holds its value.
- start is ignored in COLLECT and DONE.
- pkt_cnt is $clog2(2*cwbits+1) bits wide and never wraps; the FSM exits COLLECT exactly at 2*cwbits.
- Reset values:
  - state=IDLE
  - in_ready=0, out_valid=0
  - msg=0, err=0
  - seen=0, conflict=0, pkt_cnt=0, key_r=0
- Reset mid-frame discards the frame. The block restarts in IDLE and produces no output.

## Timing
- start accepted in cycle T: in_ready=1 from T+1.
- Each packet is accepted in one cycle; full throughput is one packet per cycle.
- Final packet accepted in cycle T: in_ready=0 and out_valid=1 from T+1.
- Latency from start to out_valid is at least 2*cwbits+1 cycles.
- out_valid stays high until the cycle out_ready=1 is sampled; it is low the following cycle.
- msg and err are stable while out_valid=1.
- A start in the same cycle as the DONE→IDLE transition is ignored. The next start is honoured one cycle later.
- msg and err are registered outputs. in_ready and out_valid are decoded from the state register; there is no combinational path from inputs.

## Configuration
- CW_STATS_EN defined:
  - Adds output chaff_cnt [15:0], a saturating count (stops at 16'hFFFF) of chaff packets accepted in the current frame.
  - chaff_cnt clears on accepted start and on reset.
  - It is held with msg through DONE.
- CW_STATS_EN undefined: no chaff_cnt port and no counter logic. All other behaviour is identical.

## Test plan
Parameters: cwbits=4, ctrsize=16, tagsize=16, key=16'hA5A5.
- Clean frame: for message 4'b1010 send 8 packets, authentic then chaff per index. For ctr=1, bit=1 the authentic tag is 16'h5A5B and the chaff tag is 16'h0000. Expect out_valid one cycle after the 8th accept, msg=4'b1010, err=0, chaff_cnt=4 if enabled.
- Reversed order with in_valid gaps: chaff first and random idle cycles. Expect the same msg=4'b1010, err=0, and out_valid exactly one cycle after the 8th accept.
- Missing index: send 8 packets where index 3 has no authentic copy (both copies chaff). Expect err=1 and msg[3]=0.
- Conflict: two authentic packets for ctr=2, bit=1 (tag 16'h5A58) then bit=0 (tag 16'hA5A7). Expect err=1 and msg[2]=1 (first value kept).
- Out-of-range counter: ctr=5 with a tag matching the formula. Expect it to be treated as chaff, msg unaffected. out_ready held low for 10 cycles: out_valid and msg stay stable, start is ignored.
- Reset mid-frame: assert rstn=0 after 3 accepts. Expect all outputs 0 and state IDLE. A following clean frame produces the correct msg with err=0.
